// File: rtl/int_arith_pkg.sv
// Shared definitions for the integer arithmetic unit.
//   div_state_t       : sequencing states of the iterative divider
//   DIV_DEFAULT_WIDTH : default operand width of the divider
//   tc_negate()       : two's-complement negate on a wide vector; callers
//                       zero-extend their operand and truncate the result
package int_arith_pkg;

    localparam int DIV_DEFAULT_WIDTH = 16;
    localparam int ARITH_MAX_WIDTH   = 64;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_ITER = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_t;

    function automatic logic [ARITH_MAX_WIDTH-1:0] tc_negate(
        input logic [ARITH_MAX_WIDTH-1:0] v
    );
        return ~v + {{(ARITH_MAX_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//   rem_i / quo_i : partial remainder and dividend/quotient shift register
//   dvs_i         : divisor magnitude
//   rem_o / quo_o : values after shifting {rem, quo} left and one trial subtract
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic       trial_ok;

    assign shifted  = {rem_i, quo_i[W-1]};
    // Trial remainder is non-negative exactly when shifted >= divisor.
    assign trial_ok = (shifted >= {1'b0, dvs_i});
    // When the trial succeeds the difference is below the divisor, so its
    // top bit is always zero and truncation loses nothing.
    assign rem_o    = trial_ok ? W'(shifted - {1'b0, dvs_i}) : shifted[W-1:0];
    assign quo_o    = {quo_i[W-2:0], trial_ok};

endmodule

// File: rtl/int_divider.sv
// Iterative restoring integer divider: one quotient bit per clock.
// Optional feature macro: INT_DIV_SIGNED_EN (adds is_signed port, signed
// magnitude handling, overflow detection). Default build is unsigned only.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start_valid/start_ready    request handshake (ready only in IDLE)
//   is_signed                  signed operation select (signed build only)
//   dividend, divisor          operands, captured on accept
//   result_valid/result_ready  response handshake (valid only in DONE)
//   quotient, remainder        results, held through DONE
//   div_by_zero, overflow      exception flags, cleared on response handshake
//
// state | meaning
// IDLE  | waiting for a request
// PREP  | zero-divisor / overflow shortcut or operand magnitudes
// ITER  | DATA_WIDTH shift/subtract steps
// FIX   | result sign correction (pass-through for unsigned and shortcuts)
// DONE  | result presented until consumed
import int_arith_pkg::*;

module int_divider #(
    parameter int DATA_WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
`ifdef INT_DIV_SIGNED_EN
    input  logic                  is_signed,
`endif
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    div_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  dz_q, dz_d;
    logic [DATA_WIDTH-1:0] step_rem, step_quo;

`ifdef INT_DIV_SIGNED_EN
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic sgn_q, sgn_d;
    logic ov_q, ov_d;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
`endif

    div_step #(.W(DATA_WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        count_d = count_q;
        dz_d    = dz_q;
`ifdef INT_DIV_SIGNED_EN
        sgn_d     = sgn_q;
        ov_d      = ov_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            DIV_IDLE: begin
                if (start_valid) begin
                    // The dividend rides in the quotient shift register.
                    quo_d   = dividend;
                    dvs_d   = divisor;
`ifdef INT_DIV_SIGNED_EN
                    sgn_d   = is_signed;
`endif
                    state_d = DIV_PREP;
                end
            end
            DIV_PREP: begin
                // Shortcuts load final values and pass through FIX untouched,
                // which keeps their latency at two cycles.
                if (dvs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = quo_q;
                    dz_d    = 1'b1;
`ifdef INT_DIV_SIGNED_EN
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
`endif
                    state_d = DIV_FIX;
                end
`ifdef INT_DIV_SIGNED_EN
                else if (sgn_q && (quo_q == MIN_VAL) && (dvs_q == '1)) begin
                    quo_d     = MIN_VAL;
                    rem_d     = '0;
                    ov_d      = 1'b1;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = DIV_FIX;
                end
`endif
                else begin
`ifdef INT_DIV_SIGNED_EN
                    neg_quo_d = sgn_q & (quo_q[DATA_WIDTH-1] ^ dvs_q[DATA_WIDTH-1]);
                    neg_rem_d = sgn_q & quo_q[DATA_WIDTH-1];
                    if (sgn_q && quo_q[DATA_WIDTH-1])
                        quo_d = DATA_WIDTH'(tc_negate(64'(quo_q)));
                    if (sgn_q && dvs_q[DATA_WIDTH-1])
                        dvs_d = DATA_WIDTH'(tc_negate(64'(dvs_q)));
`endif
                    rem_d   = '0;
                    count_d = '0;
                    state_d = DIV_ITER;
                end
            end
            DIV_ITER: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == CW'(DATA_WIDTH - 1))
                    state_d = DIV_FIX;
            end
            DIV_FIX: begin
`ifdef INT_DIV_SIGNED_EN
                if (neg_quo_q) quo_d = DATA_WIDTH'(tc_negate(64'(quo_q)));
                if (neg_rem_q) rem_d = DATA_WIDTH'(tc_negate(64'(rem_q)));
`endif
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (result_ready) begin
                    dz_d    = 1'b0;
`ifdef INT_DIV_SIGNED_EN
                    ov_d    = 1'b0;
`endif
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            count_q <= '0;
            dz_q    <= 1'b0;
`ifdef INT_DIV_SIGNED_EN
            sgn_q     <= 1'b0;
            ov_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            count_q <= count_d;
            dz_q    <= dz_d;
`ifdef INT_DIV_SIGNED_EN
            sgn_q     <= sgn_d;
            ov_q      <= ov_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign start_ready  = (state_q == DIV_IDLE);
    assign result_valid = (state_q == DIV_DONE);
    assign quotient     = quo_q;
    assign remainder    = rem_q;
    assign div_by_zero  = dz_q;
`ifdef INT_DIV_SIGNED_EN
    assign overflow     = ov_q;
`else
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_int_divider.sv
module tb_int_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
`ifdef INT_DIV_SIGNED_EN
    logic         is_signed = 1'b0;
`endif
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    exp_t sb[$];

    int_divider #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
`ifdef INT_DIV_SIGNED_EN
        .is_signed    (is_signed),
`endif
        .dividend     (dividend),
        .divisor      (divisor),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        exp_t e;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = W + 2;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 2;
        end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
            e.q = 16'h8000; e.r = '0; e.ov = 1'b1; e.lat = 2;
        end else if (sg) begin
            e.q = W'($signed(a) / $signed(b));
            e.r = W'($signed(a) % $signed(b));
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Issue one request and wait for the result; leaves the DUT in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sg, input string tag);
        exp_t e;
        int   cyc;
        sb.push_back(model(a, b, sg));
        @(negedge clk);
        dividend    = a;
        divisor     = b;
`ifdef INT_DIV_SIGNED_EN
        is_signed   = sg;
`endif
        start_valid = 1'b1;
        chk({tag, "/start_ready_idle"}, 32'(start_ready), 32'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dividend    = ~a;
        divisor     = W'($urandom);
`ifdef INT_DIV_SIGNED_EN
        is_signed   = ~sg;
`endif
        chk({tag, "/start_ready_busy"}, 32'(start_ready), 32'd0);
        cyc = 0;
        while (!result_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, "/latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, "/quotient"}, 32'(quotient), 32'(e.q));
        chk({tag, "/remainder"}, 32'(remainder), 32'(e.r));
        chk({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
        chk({tag, "/overflow"}, 32'(overflow), 32'(e.ov));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk({tag, "/valid_after_hs"}, 32'(result_valid), 32'd0);
        chk({tag, "/ready_after_hs"}, 32'(start_ready), 32'd1);
        chk({tag, "/flags_clear"}, 32'({div_by_zero, overflow}), 32'd0);
    endtask

    initial begin
        logic [W-1:0] hq, hr;

        #1;
        chk("reset/start_ready", 32'(start_ready), 32'd1);
        chk("reset/result_valid", 32'(result_valid), 32'd0);
        chk("reset/quotient", 32'(quotient), 32'd0);
        chk("reset/remainder", 32'(remainder), 32'd0);
        chk("reset/flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd100, 16'd7, 1'b0, "u100_7");
        release_result("u100_7");

        run_op(16'hFFF9, 16'd2, 1'b0, "u_fff9_2");
        release_result("u_fff9_2");

        run_op(16'd5, 16'd0, 1'b0, "div0");
        release_result("div0");

        run_op(16'hFFFF, 16'hFFFF, 1'b0, "u_max_max");
        release_result("u_max_max");

        run_op(16'd3, 16'd9, 1'b0, "u_small");
        release_result("u_small");

`ifdef INT_DIV_SIGNED_EN
        run_op(16'hFFF9, 16'd2, 1'b1, "s_m7_2");
        release_result("s_m7_2");
        run_op(16'h8000, 16'hFFFF, 1'b1, "s_ovf");
        release_result("s_ovf");
        run_op(16'd100, 16'hFFF9, 1'b1, "s_100_m7");
        release_result("s_100_m7");
        run_op(16'h8000, 16'd0, 1'b1, "s_div0");
        release_result("s_div0");
`endif

        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom_range(1, 300)), 1'b0, "rnd");
            release_result("rnd");
        end

        // Backpressure: result held, no new request accepted while in DONE.
        run_op(16'd1000, 16'd33, 1'b0, "bp");
        hq = quotient;
        hr = remainder;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            dividend    = 16'd7;
            divisor     = 16'd1;
            chk("bp/valid_held", 32'(result_valid), 32'd1);
            chk("bp/start_ready_low", 32'(start_ready), 32'd0);
            chk("bp/quotient_stable", 32'(quotient), 32'(16'd30));
            chk("bp/remainder_stable", 32'(remainder), 32'(16'd10));
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        start_valid  = 1'b0;
        chk("bp/ready_after_hs", 32'(start_ready), 32'd1);
        chk("bp/valid_after_hs", 32'(result_valid), 32'd0);
        chk("bp/held_q_matches", 32'(hq), 32'(16'd30));
        chk("bp/held_r_matches", 32'(hr), 32'(16'd10));
        @(posedge clk);
        #1;
        chk("bp/no_accept_in_done", 32'(start_ready), 32'd1);

        // Reset mid-ITER discards the operation.
        @(negedge clk);
        dividend    = 16'd100;
        divisor     = 16'd7;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/start_ready", 32'(start_ready), 32'd1);
        chk("rst_mid/result_valid", 32'(result_valid), 32'd0);
        chk("rst_mid/quotient", 32'(quotient), 32'd0);
        chk("rst_mid/remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd100, 16'd7, 1'b0, "after_rst");
        release_result("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
